// File: rtl/alu_pkg.sv
// Shared constants for the EX-stage ALU selection decoder and the M-extension sequencer.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_LUI  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1101;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    localparam logic [1:0] ALUOP_LDST  = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_LUI   = 2'b11;

    localparam logic [6:0] FUN7_BASE   = 7'b0000000;
    localparam logic [6:0] FUN7_ALT    = 7'b0100000;
    localparam logic [6:0] FUN7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_DONE = 2'b10
    } md_state_t;

endpackage

// File: rtl/alu_ctrl_md_core.sv
// Iterative unsigned shift-add multiplier and restoring divider, one step per cycle.
module md_iter_core #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              run,
    input  logic              fast_done,
    input  logic [XLEN-1:0]   a_mag,
    input  logic [XLEN-1:0]   b_mag,
    output logic              last,
    output logic              done,
    output logic [2*XLEN-1:0] acc_next,
    output logic [XLEN-1:0]   quo_next,
    output logic [XLEN-1:0]   rem_next
);
    localparam int CW = $clog2(XLEN);

    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   quo, rem, mcand, dsor;
    logic [CW-1:0]     cnt;
    logic [XLEN:0]     psum;
    logic [XLEN:0]     rshift;
    logic [XLEN+1:0]   diff;

    // The next-step values are exported so the final step can be fixed up in the same edge.
    always_comb begin
        psum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_next = {psum, acc[XLEN-1:1]};
        rshift   = {rem, quo[XLEN-1]};
        diff     = {1'b0, rshift} - {2'b00, dsor};
        if (diff[XLEN+1]) begin
            rem_next = rshift[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end else begin
            rem_next = diff[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end
    end

    assign last = run && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt   <= '0;
            done  <= 1'b0;
            acc   <= '0;
            quo   <= '0;
            rem   <= '0;
            mcand <= '0;
            dsor  <= '0;
        end else begin
            done <= last || fast_done;
            if (load) begin
                cnt   <= CW'(XLEN - 1);
                acc   <= {{XLEN{1'b0}}, b_mag};
                quo   <= a_mag;
                rem   <= '0;
                mcand <= a_mag;
                dsor  <= b_mag;
            end else if (run) begin
                acc <= acc_next;
                quo <= quo_next;
                rem <= rem_next;
                if (cnt != '0) cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_ctrl_md.sv
// EX-stage ALU selection decoder with an attached iterative RV32M/RV64M sequencer.
module alu_ctrl_md
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter bit M_EXT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            flush,
    input  logic [1:0]      ALUOp,
    input  logic [2:0]      fun3,
    input  logic [6:0]      fun7,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic [3:0]      ALU_Selection,
    output logic            md_sel,
    output logic            stall,
    output logic            md_done,
    output logic [XLEN-1:0] md_result
);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t         state;
    logic [2:0]        op_q;
    logic              neg_a_q, neg_b_q;
    logic              start, fast, div_zero, div_ovf, signed_a, signed_b, neg_a_in, neg_b_in;
    logic              core_last;
    logic [XLEN-1:0]   a_mag, b_mag, fast_res, fix_res, quo_fix, rem_fix;
    logic [2*XLEN-1:0] acc_next, prod_fix;
    logic [XLEN-1:0]   quo_next, rem_next;

    // M-type encodings are kept off the ALU path and decode as add.
    always_comb begin
        ALU_Selection = ALU_ADD;
        case (ALUOp)
            ALUOP_LDST: ALU_Selection = ALU_ADD;
            ALUOP_BR:   ALU_Selection = ALU_SUB;
            ALUOP_LUI:  ALU_Selection = ALU_LUI;
            ALUOP_RTYPE: begin
                if (fun7 != FUN7_MULDIV) begin
                    case (fun3)
                        3'b000: ALU_Selection = (fun7 == FUN7_ALT) ? ALU_SUB : ALU_ADD;
                        3'b111: ALU_Selection = ALU_AND;
                        3'b110: ALU_Selection = ALU_OR;
                        3'b100: ALU_Selection = ALU_XOR;
                        3'b001: ALU_Selection = ALU_SLL;
                        3'b010: ALU_Selection = ALU_SLT;
                        3'b011: ALU_Selection = ALU_SLTU;
                        3'b101: ALU_Selection = (fun7 == FUN7_ALT) ? ALU_SRA : ALU_SRL;
                    endcase
                end
            end
        endcase
    end

    assign md_sel   = M_EXT && (ALUOp == ALUOP_RTYPE) && (fun7 == FUN7_MULDIV);
    assign start    = ex_valid && md_sel && (state == MD_IDLE) && !flush;
    assign stall    = start || (state == MD_RUN);

    assign div_zero = (rs2_val == '0);
    assign div_ovf  = !fun3[0] && (rs1_val == SMIN) && (rs2_val == '1);
    assign fast     = fun3[2] && (div_zero || div_ovf);
    assign fast_res = fun3[1] ? (div_zero ? rs1_val : '0) : (div_zero ? '1 : rs1_val);

    assign signed_a = (fun3 == F3_MULH) || (fun3 == F3_MULHSU) || (fun3 == F3_DIV) || (fun3 == F3_REM);
    assign signed_b = (fun3 == F3_MULH) || (fun3 == F3_DIV) || (fun3 == F3_REM);
    assign neg_a_in = signed_a && rs1_val[XLEN-1];
    assign neg_b_in = signed_b && rs2_val[XLEN-1];
    assign a_mag    = neg_a_in ? -rs1_val : rs1_val;
    assign b_mag    = neg_b_in ? -rs2_val : rs2_val;

    md_iter_core #(.XLEN(XLEN)) u_core (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .load      (start && !fast),
        .run       (state == MD_RUN),
        .fast_done (start && fast),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .last      (core_last),
        .done      (md_done),
        .acc_next  (acc_next),
        .quo_next  (quo_next),
        .rem_next  (rem_next)
    );

    // Sign fix-up on the magnitudes coming out of the final iteration.
    always_comb begin
        prod_fix = (neg_a_q ^ neg_b_q) ? -acc_next : acc_next;
        quo_fix  = (neg_a_q ^ neg_b_q) ? -quo_next : quo_next;
        rem_fix  = neg_a_q ? -rem_next : rem_next;
        case (op_q)
            F3_MUL:                      fix_res = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:             fix_res = quo_fix;
            default:                     fix_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MD_IDLE;
            md_result <= '0;
            op_q      <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
        end else if (flush) begin
            state <= MD_IDLE;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        op_q    <= fun3;
                        neg_a_q <= neg_a_in;
                        neg_b_q <= neg_b_in;
                        if (fast) begin
                            state     <= MD_DONE;
                            md_result <= fast_res;
                        end else begin
                            state <= MD_RUN;
                        end
                    end
                end
                MD_RUN: begin
                    if (core_last) begin
                        state     <= MD_DONE;
                        md_result <= fix_res;
                    end
                end
                MD_DONE: state <= MD_IDLE;
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule
